machine_timer: RTL and testbench

- Memory-mapped machine timer: free-running 64-bit mtime counter with prescaler, 64-bit mtimecmp compare register, sticky pending flag.
- Sits directly upstream of the interrupt controller; drives its single-bit `timer` input with a one-cycle pulse.
- The core's load/store unit reaches it through a simple 32-bit register port.

---
 rtl/machine_timer_if.sv | 37 +++
 rtl/machine_timer.sv | 178 +++++++++++++++++
 tb/tb_machine_timer.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/machine_timer_if.sv
// -----------------------------------------------------------------------------
// machine_timer_if
//   32-bit register port between the core's load/store unit and the machine
//   timer. Reads return data one cycle after the strobe.
//
//   bus_addr  [2:0]  word address (byte address bits [4:2])
//   bus_wr           single-cycle write strobe
//   bus_rd           single-cycle read strobe
//   bus_wdata [31:0] write data
//   bus_rdata [31:0] registered read data, valid the cycle after bus_rd
//
//   master : the load/store unit (drives address, strobes, write data)
//   slave  : the timer (drives read data)
// -----------------------------------------------------------------------------
interface machine_timer_if;
    logic [2:0]  bus_addr;
    logic        bus_wr;
    logic        bus_rd;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;

    modport master (
        output bus_addr,
        output bus_wr,
        output bus_rd,
        output bus_wdata,
        input  bus_rdata
    );

    modport slave (
        input  bus_addr,
        input  bus_wr,
        input  bus_rd,
        input  bus_wdata,
        output bus_rdata
    );
endinterface

// File: rtl/machine_timer.sv
// -----------------------------------------------------------------------------
// machine_timer
//   Memory-mapped machine timer: a free-running 64-bit mtime counter advanced
//   by a programmable prescaler, a 64-bit mtimecmp compare register, a sticky
//   pending flag and a one-cycle interrupt pulse toward the interrupt
//   controller.
//
//   Ports:
//     clk      system clock
//     rst      synchronous active-high reset
//     host     register port (slave side of machine_timer_if)
//     timer    one-cycle interrupt pulse, raised when mtime >= mtimecmp first
//              becomes true and IRQ_EN is set
//     pending  sticky pending flag (level), independent of IRQ_EN
//
//   Register map (word addresses):
//     0 CTRL        bit0 EN, bit1 PERIODIC, bit2 IRQ_EN
//     1 PRESCALE    [PRESCALE_W-1:0]; writing it restarts the prescaler
//     2 MTIME_LO    3 MTIME_HI
//     4 MTIMECMP_LO 5 MTIMECMP_HI
//     6 STATUS      bit0 PENDING, write 1 to clear
//     7 reserved    reads 0, writes ignored
// -----------------------------------------------------------------------------
module machine_timer #(
    parameter int                    PRESCALE_W   = 16,
    parameter logic [PRESCALE_W-1:0] PRESCALE_RST = '0
) (
    input  logic             clk,
    input  logic             rst,
    machine_timer_if.slave   host,
    output logic             timer,
    output logic             pending
);

    typedef enum logic [2:0] {
        ADDR_CTRL        = 3'd0,
        ADDR_PRESCALE    = 3'd1,
        ADDR_MTIME_LO    = 3'd2,
        ADDR_MTIME_HI    = 3'd3,
        ADDR_MTIMECMP_LO = 3'd4,
        ADDR_MTIMECMP_HI = 3'd5,
        ADDR_STATUS      = 3'd6,
        ADDR_RSVD        = 3'd7
    } reg_addr_e;

    // Architectural state
    logic                  ctrl_en;
    logic                  ctrl_periodic;
    logic                  ctrl_irq_en;
    logic [PRESCALE_W-1:0] prescale;
    logic [PRESCALE_W-1:0] pre_cnt;
    logic [63:0]           mtime;
    logic [63:0]           mtimecmp;
    logic                  match_prev;
    logic                  pending_q;

    // Combinational helpers
    reg_addr_e             addr;
    logic                  tick;
    logic                  match;
    logic                  rise;
    logic                  wr_ctrl;
    logic                  wr_prescale;
    logic                  wr_mtime_lo;
    logic                  wr_mtime_hi;
    logic                  wr_cmp_lo;
    logic                  wr_cmp_hi;
    logic                  clr_pending;
    logic [31:0]           rdata_sel;

    assign addr = reg_addr_e'(host.bus_addr);

    assign wr_ctrl     = host.bus_wr && (addr == ADDR_CTRL);
    assign wr_prescale = host.bus_wr && (addr == ADDR_PRESCALE);
    assign wr_mtime_lo = host.bus_wr && (addr == ADDR_MTIME_LO);
    assign wr_mtime_hi = host.bus_wr && (addr == ADDR_MTIME_HI);
    assign wr_cmp_lo   = host.bus_wr && (addr == ADDR_MTIMECMP_LO);
    assign wr_cmp_hi   = host.bus_wr && (addr == ADDR_MTIMECMP_HI);
    assign clr_pending = host.bus_wr && (addr == ADDR_STATUS) && host.bus_wdata[0];

    // The prescaler counts 0..PRESCALE, so the tick period is PRESCALE+1 clocks.
    assign tick  = ctrl_en && (pre_cnt == prescale);
    // Compare runs even while disabled, so rewriting mtimecmp can fire an IRQ.
    assign match = (mtime >= mtimecmp);
    assign rise  = match && !match_prev;

    assign pending = pending_q;

    // Read mux works on current register values, so a read that collides
    // with a write to the same address returns the pre-write contents.
    always_comb begin
        // NOTE: default assignment first so no path leaves rdata_sel unassigned,
        // which would otherwise infer a latch.
        rdata_sel = '0;
        case (addr)
            ADDR_CTRL:        rdata_sel = {29'd0, ctrl_irq_en, ctrl_periodic, ctrl_en};
            ADDR_PRESCALE:    rdata_sel = 32'(prescale);
            ADDR_MTIME_LO:    rdata_sel = mtime[31:0];
            ADDR_MTIME_HI:    rdata_sel = mtime[63:32];
            ADDR_MTIMECMP_LO: rdata_sel = mtimecmp[31:0];
            ADDR_MTIMECMP_HI: rdata_sel = mtimecmp[63:32];
            ADDR_STATUS:      rdata_sel = {31'd0, pending_q};
            ADDR_RSVD:        rdata_sel = '0;
            default:          rdata_sel = '0;
        endcase
    end

    // NOTE: all state uses non-blocking assignments so every register samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_en          <= 1'b0;
            ctrl_periodic    <= 1'b0;
            ctrl_irq_en      <= 1'b0;
            prescale         <= PRESCALE_RST;
            pre_cnt          <= '0;
            mtime            <= '0;
            mtimecmp         <= '1;
            match_prev       <= 1'b0;
            pending_q        <= 1'b0;
            timer            <= 1'b0;
            host.bus_rdata   <= '0;
        end else begin
            if (wr_ctrl) begin
                ctrl_en       <= host.bus_wdata[0];
                ctrl_periodic <= host.bus_wdata[1];
                ctrl_irq_en   <= host.bus_wdata[2];
            end

            // Prescaler: a PRESCALE write restarts the count; disabled holds 0.
            if (wr_prescale) begin
                prescale <= host.bus_wdata[PRESCALE_W-1:0];
                pre_cnt  <= '0;
            end else if (!ctrl_en || tick) begin
                pre_cnt  <= '0;
            end else begin
                pre_cnt  <= pre_cnt + PRESCALE_W'(1);
            end

            // A software write to either half wins over a coincident tick,
            // and the increment for that tick is lost.
            if (wr_mtime_lo) begin
                mtime[31:0]  <= host.bus_wdata;
            end else if (wr_mtime_hi) begin
                mtime[63:32] <= host.bus_wdata;
            end else if (tick) begin
                if (ctrl_periodic && match) begin
                    mtime <= '0;
                end else begin
                    mtime <= mtime + 64'd1;
                end
            end

            if (wr_cmp_lo) begin
                mtimecmp[31:0]  <= host.bus_wdata;
            end
            if (wr_cmp_hi) begin
                mtimecmp[63:32] <= host.bus_wdata;
            end

            match_prev <= match;

            // A rise in the same cycle as a clear keeps the flag set.
            if (rise) begin
                pending_q <= 1'b1;
            end else if (clr_pending) begin
                pending_q <= 1'b0;
            end

            timer <= rise && ctrl_irq_en;

            if (host.bus_rd) begin
                host.bus_rdata <= rdata_sel;
            end
        end
    end

endmodule

// File: tb/tb_machine_timer.sv
// -----------------------------------------------------------------------------
// tb_machine_timer
//   Directed testbench for machine_timer. Inputs change on the falling edge;
//   every bus task is entered and left on a falling edge and a write or read
//   occupies exactly one clock. Outputs are sampled on the falling edge or
//   1 time unit after the rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_machine_timer;

    localparam logic [2:0] A_CTRL     = 3'd0;
    localparam logic [2:0] A_PRESCALE = 3'd1;
    localparam logic [2:0] A_MT_LO    = 3'd2;
    localparam logic [2:0] A_MT_HI    = 3'd3;
    localparam logic [2:0] A_CMP_LO   = 3'd4;
    localparam logic [2:0] A_CMP_HI   = 3'd5;
    localparam logic [2:0] A_STATUS   = 3'd6;

    logic clk;
    logic rst;
    logic timer;
    logic pending;

    int check_cnt   = 0;
    int pass_cnt    = 0;
    int fail_cnt    = 0;
    int pulse_total = 0;

    logic [31:0] exp_rst [8];

    machine_timer_if bus_if ();

    machine_timer #(
        .PRESCALE_W   (16),
        .PRESCALE_RST (16'd0)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .host    (bus_if),
        .timer   (timer),
        .pending (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each timer pulse is counted at the rising edge that ends it.
    always @(posedge clk) begin
        if (timer === 1'b1) pulse_total <= pulse_total + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        bus_if.bus_addr  = a;
        bus_if.bus_wdata = d;
        bus_if.bus_wr    = 1'b1;
        @(negedge clk);
        bus_if.bus_wr    = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        bus_if.bus_addr = a;
        bus_if.bus_rd   = 1'b1;
        @(negedge clk);
        bus_if.bus_rd   = 1'b0;
        d = bus_if.bus_rdata;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] rd2;
        int          first_pulse;
        int          pulses;
        int          snap;

        exp_rst = '{32'h0, 32'h0, 32'h0, 32'h0,
                    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0};

        rst              = 1'b1;
        bus_if.bus_addr  = '0;
        bus_if.bus_wr    = 1'b0;
        bus_if.bus_rd    = 1'b0;
        bus_if.bus_wdata = '0;
        idle(3);
        rst = 1'b0;

        // ---- Reset state ----------------------------------------------------
        check("rst_timer", 64'(timer), 64'd0);
        check("rst_pending", 64'(pending), 64'd0);
        for (int i = 0; i < 8; i++) begin
            bus_read(3'(i), rd);
            check($sformatf("rst_read[%0d]", i), 64'(rd), 64'(exp_rst[i]));
        end
        check("rst_no_pulse", 64'(pulse_total), 64'd0);

        // ---- One-shot compare with prescaler 3 ------------------------------
        bus_write(A_PRESCALE, 32'hABCD_0003);
        bus_read(A_PRESCALE, rd);
        check("prescale_rd", 64'(rd), 64'h3);
        bus_write(A_CMP_HI, 32'h0);
        // Read and write the same register in one cycle: old value returned.
        bus_if.bus_addr  = A_CMP_LO;
        bus_if.bus_wdata = 32'd5;
        bus_if.bus_wr    = 1'b1;
        bus_if.bus_rd    = 1'b1;
        @(negedge clk);
        bus_if.bus_wr    = 1'b0;
        bus_if.bus_rd    = 1'b0;
        check("rw_same_addr_old", 64'(bus_if.bus_rdata), 64'hFFFF_FFFF);
        bus_read(A_CMP_LO, rd);
        check("cmp_lo_rd", 64'(rd), 64'd5);

        // mtime reaches 5 after 20 clocks; the pulse follows one clock later.
        bus_write(A_CTRL, 32'hFFFF_FFF5);
        first_pulse = 0;
        pulses      = 0;
        for (int i = 1; i <= 130; i++) begin
            @(posedge clk);
            #1;
            if (timer === 1'b1) begin
                pulses++;
                if (first_pulse == 0) first_pulse = i;
            end
        end
        @(negedge clk);
        check("oneshot_pulse_cycle", 64'(first_pulse), 64'd21);
        check("oneshot_pulse_count", 64'(pulses), 64'd1);
        check("oneshot_pending", 64'(pending), 64'd1);
        bus_read(A_CTRL, rd);
        check("ctrl_rd_masked", 64'(rd), 64'd5);
        bus_read(A_STATUS, rd);
        check("status_rd", 64'(rd), 64'd1);
        bus_read(A_MT_LO, rd);
        idle(7);
        bus_read(A_MT_LO, rd2);
        check("mtime_rate_div4", 64'(rd2 - rd), 64'd2);

        // ---- Periodic mode, period 4 ----------------------------------------
        bus_write(A_CTRL, 32'h0);
        bus_write(A_MT_LO, 32'h0);
        bus_write(A_MT_HI, 32'h0);
        bus_write(A_STATUS, 32'h1);
        check("status_clear", 64'(pending), 64'd0);
        bus_write(A_CMP_LO, 32'd3);
        bus_write(A_PRESCALE, 32'd0);
        bus_write(A_CTRL, 32'd7);
        bus_if.bus_addr = A_MT_LO;
        bus_if.bus_rd   = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk);
            #1;
            if (i <= 8) begin
                check($sformatf("periodic_mtime[%0d]", i), 64'(bus_if.bus_rdata), 64'((i - 1) % 4));
            end
            check($sformatf("periodic_timer[%0d]", i), 64'(timer), 64'((i % 4) == 0));
        end
        @(negedge clk);
        bus_if.bus_rd = 1'b0;

        // ---- Clear coincident with rise; compare while disabled -------------
        bus_write(A_CTRL, 32'd4);
        bus_write(A_CMP_LO, 32'hFFFF_FFFF);
        bus_write(A_MT_LO, 32'd7);
        bus_write(A_STATUS, 32'h1);
        idle(1);
        check("pending_cleared_idle", 64'(pending), 64'd0);
        snap = pulse_total;
        bus_write(A_CMP_LO, 32'd7);
        bus_write(A_STATUS, 32'h1);
        check("set_wins_over_clear", 64'(pending), 64'd1);
        idle(2);
        check("disabled_cmp_pulse", 64'(pulse_total), 64'(snap + 1));
        bus_write(A_STATUS, 32'h1);
        check("later_clear", 64'(pending), 64'd0);
        idle(10);
        check("no_repeat_match_high", 64'(pulse_total), 64'(snap + 1));

        // ---- 64-bit wrap and write-over-tick priority -----------------------
        bus_write(A_CTRL, 32'd0);
        bus_write(A_MT_LO, 32'hFFFF_FFFF);
        bus_write(A_MT_HI, 32'hFFFF_FFFF);
        bus_read(A_MT_HI, rd);
        check("mtime_hi_allones", 64'(rd), 64'hFFFF_FFFF);
        snap = pulse_total;
        bus_write(A_CTRL, 32'd1);
        bus_write(A_CTRL, 32'd0);
        bus_read(A_MT_LO, rd);
        check("wrap_lo", 64'(rd), 64'd0);
        bus_read(A_MT_HI, rd);
        check("wrap_hi", 64'(rd), 64'd0);
        bus_write(A_CTRL, 32'd1);
        bus_write(A_MT_LO, 32'd10);
        bus_read(A_MT_LO, rd);
        check("write_beats_tick", 64'(rd), 64'd10);
        bus_write(A_CTRL, 32'd0);
        check("pending_without_irq_en", 64'(pending), 64'd1);
        check("no_pulse_irq_disabled", 64'(pulse_total), 64'(snap));

        // ---- Reset mid-count ------------------------------------------------
        bus_write(A_PRESCALE, 32'd3);
        bus_write(A_MT_LO, 32'd7);
        bus_write(A_MT_HI, 32'd0);
        bus_write(A_CTRL, 32'd5);
        idle(2);
        check("pre_reset_pending", 64'(pending), 64'd1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check("midrst_timer", 64'(timer), 64'd0);
        check("midrst_pending", 64'(pending), 64'd0);
        snap = pulse_total;
        for (int i = 0; i < 8; i++) begin
            bus_read(3'(i), rd);
            check($sformatf("midrst_read[%0d]", i), 64'(rd), 64'(exp_rst[i]));
        end
        idle(20);
        check("midrst_no_pulse", 64'(pulse_total), 64'(snap));

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
